// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared slot indices, boundary codes and FSM encodings for pipeline control
package pipe_stall_ctrl_pkg;

    localparam int NUM_SLOTS = 7;

    // Pipeline slot indices, front to back
    localparam int SLOT_PC   = 0;
    localparam int SLOT_IF   = 1;
    localparam int SLOT_ID   = 2;
    localparam int SLOT_EX   = 3;
    localparam int SLOT_MEM1 = 4;
    localparam int SLOT_MEM2 = 5;
    localparam int SLOT_WB   = 6;

    // Boundary bus codes {src_stalled, dst_stalled}; 2'b01 also advances
    localparam logic [1:0] BND_ADV    = 2'b00;
    localparam logic [1:0] BND_BUBBLE = 2'b10;
    localparam logic [1:0] BND_HOLD   = 2'b11;

    // Fixed stall patterns used while sequencing a redirect
    localparam logic [NUM_SLOTS-1:0] STALL_EXC_DETECT = 7'b0111111;
    localparam logic [NUM_SLOTS-1:0] STALL_DRAIN      = 7'b0000011;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, async active-low reset
// Ports: clk, resetn (async, active-low), inc (count enable), count (CNT_W, sticks at all-ones)
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - 7-slot pipeline stall vector, exception/eret redirect sequencing and stall counter
// Ports: clk, resetn (async, active-low); stallreq_{if,id,ex,mem1,mem2} per-slot hold requests;
//        if_busy fetch outstanding; exc_valid/exc_is_eret/cp0_epc committed exception at mem2;
//        stall[6:0] per-slot stall, stall_<a><b> boundary buses {stall[k], stall[k+1]};
//        flush, new_pc, new_pc_valid redirect; if_discard drop returning fetch; stall_cnt stall cycles
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VEC_DEFAULT),
    parameter int                CNT_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem1,
    input  logic              stallreq_mem2,
    input  logic              if_busy,
    input  logic              exc_valid,
    input  logic              exc_is_eret,
    input  logic [ADDR_W-1:0] cp0_epc,
    output logic [6:0]        stall,
    output logic [1:0]        stall_pcif,
    output logic [1:0]        stall_ifid,
    output logic [1:0]        stall_idex,
    output logic [1:0]        stall_expt1_mempt1,
    output logic [1:0]        stall_mem1mem2,
    output logic [1:0]        stall_mem2wb,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic              new_pc_valid,
    output logic              if_discard,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t     state;
    logic       busy_at_flush;
    logic [6:0] stall_run;

    // A request from slot j holds every slot in front of it: suffix OR from mem2 down to pc.
    always_comb begin
        stall_run            = '0;
        stall_run[SLOT_MEM2] = stallreq_mem2;
        stall_run[SLOT_MEM1] = stallreq_mem1 | stall_run[SLOT_MEM2];
        stall_run[SLOT_EX]   = stallreq_ex   | stall_run[SLOT_MEM1];
        stall_run[SLOT_ID]   = stallreq_id   | stall_run[SLOT_EX];
        stall_run[SLOT_IF]   = stallreq_if   | stall_run[SLOT_ID];
        stall_run[SLOT_PC]   = stall_run[SLOT_IF];
        stall_run[SLOT_WB]   = 1'b0;
    end

    // Exception detection overrides the requests so wb bubbles and the faulting
    // instruction is not duplicated. Outputs are forced low while reset is held.
    always_comb begin
        stall = '0;
        case (state)
            ST_RUN:   stall = exc_valid ? STALL_EXC_DETECT : stall_run;
            ST_FLUSH: stall = '0;
            ST_DRAIN: stall = STALL_DRAIN;
            default:  stall = '0;
        endcase
        if (!resetn) begin
            stall = '0;
        end
    end

    assign stall_pcif         = {stall[SLOT_PC],   stall[SLOT_IF]};
    assign stall_ifid         = {stall[SLOT_IF],   stall[SLOT_ID]};
    assign stall_idex         = {stall[SLOT_ID],   stall[SLOT_EX]};
    assign stall_expt1_mempt1 = {stall[SLOT_EX],   stall[SLOT_MEM1]};
    assign stall_mem1mem2     = {stall[SLOT_MEM1], stall[SLOT_MEM2]};
    assign stall_mem2wb       = {stall[SLOT_MEM2], stall[SLOT_WB]};

    // Redirect sequencer. flush/new_pc_valid/if_discard are registered together with
    // the state so each is exactly the decode of the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_RUN;
            busy_at_flush <= 1'b0;
            new_pc        <= '0;
            flush         <= 1'b0;
            new_pc_valid  <= 1'b0;
            if_discard    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exc_valid) begin
                        state         <= ST_FLUSH;
                        new_pc        <= exc_is_eret ? cp0_epc : EXC_VEC;
                        busy_at_flush <= if_busy;
                        flush         <= 1'b1;
                        new_pc_valid  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush        <= 1'b0;
                    new_pc_valid <= 1'b0;
                    // A fetch issued before the redirect may still be returning
                    if (busy_at_flush || if_busy) begin
                        state      <= ST_DRAIN;
                        if_discard <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!if_busy) begin
                        state      <= ST_RUN;
                        if_discard <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_RUN;
                    flush        <= 1'b0;
                    new_pc_valid <= 1'b0;
                    if_discard   <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .resetn(resetn),
        .inc   (|stall),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

    localparam logic [31:0] EXC = 32'hBFC00380;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic        stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem1 = 0, stallreq_mem2 = 0;
    logic        if_busy = 0, exc_valid = 0, exc_is_eret = 0;
    logic [31:0] cp0_epc = '0;

    logic [6:0]  stall, stall_s;
    logic [1:0]  stall_pcif, stall_ifid, stall_idex, stall_expt1_mempt1, stall_mem1mem2, stall_mem2wb;
    logic [1:0]  b0_s, b1_s, b2_s, b3_s, b4_s, b5_s;
    logic        flush, new_pc_valid, if_discard, flush_s, new_pc_valid_s, if_discard_s;
    logic [31:0] new_pc, new_pc_s, stall_cnt;
    logic [3:0]  stall_cnt4;

    pipe_stall_ctrl dut (
        .clk(clk), .resetn(resetn),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem1(stallreq_mem1), .stallreq_mem2(stallreq_mem2),
        .if_busy(if_busy), .exc_valid(exc_valid), .exc_is_eret(exc_is_eret), .cp0_epc(cp0_epc),
        .stall(stall), .stall_pcif(stall_pcif), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_expt1_mempt1(stall_expt1_mempt1), .stall_mem1mem2(stall_mem1mem2), .stall_mem2wb(stall_mem2wb),
        .flush(flush), .new_pc(new_pc), .new_pc_valid(new_pc_valid), .if_discard(if_discard),
        .stall_cnt(stall_cnt)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem1(stallreq_mem1), .stallreq_mem2(stallreq_mem2),
        .if_busy(if_busy), .exc_valid(exc_valid), .exc_is_eret(exc_is_eret), .cp0_epc(cp0_epc),
        .stall(stall_s), .stall_pcif(b0_s), .stall_ifid(b1_s), .stall_idex(b2_s),
        .stall_expt1_mempt1(b3_s), .stall_mem1mem2(b4_s), .stall_mem2wb(b5_s),
        .flush(flush_s), .new_pc(new_pc_s), .new_pc_valid(new_pc_valid_s), .if_discard(if_discard_s),
        .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: mode 0 = running, 1 = redirect pulse cycle, 2 = waiting out a stale fetch
    int          mode;
    logic        busy_m;
    logic [31:0] pc_m;
    longint      cnt_m;
    int          cnt4_m;

    task automatic model_reset();
        mode = 0; busy_m = 0; pc_m = '0; cnt_m = 0; cnt4_m = 0;
    endtask

    function automatic logic [6:0] model_stall();
        logic [6:0] s;
        logic [5:1] r;
        s = '0;
        if (!resetn)   return 7'b0;
        if (mode == 1) return 7'b0;
        if (mode == 2) return 7'b0000011;
        if (exc_valid) return 7'b0111111;
        r = {stallreq_mem2, stallreq_mem1, stallreq_ex, stallreq_id, stallreq_if};
        for (int j = 1; j <= 5; j++)
            if (r[j]) s = s | 7'((1 << (j + 1)) - 1);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [6:0]  s;
        logic [11:0] bexp;
        s = model_stall();
        for (int k = 0; k < 6; k++) bexp[11 - 2*k -: 2] = {s[k], s[k+1]};
        chk("stall", stall, s);
        chk("boundary", {stall_pcif, stall_ifid, stall_idex, stall_expt1_mempt1, stall_mem1mem2, stall_mem2wb}, bexp);
        chk("flush", flush, mode == 1 && resetn);
        chk("new_pc_valid", new_pc_valid, mode == 1 && resetn);
        chk("if_discard", if_discard, mode == 2 && resetn);
        chk("new_pc", new_pc, pc_m);
        chk("stall_cnt", stall_cnt, cnt_m);
        chk("stall_cnt4", stall_cnt4, cnt4_m);
    endtask

    task automatic model_edge();
        logic [6:0] s;
        s = model_stall();
        if (!resetn) return;
        if (s != 0) begin
            if (cnt_m < 64'hFFFFFFFF) cnt_m++;
            if (cnt4_m < 15) cnt4_m++;
        end
        case (mode)
            0: if (exc_valid) begin
                   mode   = 1;
                   pc_m   = exc_is_eret ? cp0_epc : EXC;
                   busy_m = if_busy;
               end
            1: mode = (busy_m || if_busy) ? 2 : 0;
            default: if (!if_busy) mode = 0;
        endcase
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem1, stallreq_mem2} = '0;
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        resetn = 1'b1;
        cycle();

        // ex busy holds the front four slots; bubble into mem1
        stallreq_ex = 1;
        #1;
        chk("ex_stall_lit", stall, 7'b0001111);
        chk("ex_bnd_bubble", stall_expt1_mempt1, 2'b10);
        chk("ex_bnd_hold", stall_idex, 2'b11);
        cycle();
        cycle();
        stallreq_ex = 0;
        #1;
        chk("ex_release", stall, 7'b0);
        cycle();

        // if and mem2 together
        stallreq_if = 1; stallreq_mem2 = 1;
        #1;
        chk("ifmem2_stall_lit", stall, 7'b0111111);
        chk("ifmem2_bnd", stall_mem2wb, 2'b10);
        repeat (3) cycle();
        clear_reqs();
        cycle();

        // exception, no fetch outstanding, with a competing stall request
        exc_valid = 1; exc_is_eret = 0; if_busy = 0; stallreq_id = 1;
        #1;
        chk("exc_detect_stall", stall, 7'b0111111);
        cycle();
        exc_valid = 0; clear_reqs();
        #1;
        chk("exc_flush_lit", flush, 1'b1);
        chk("exc_newpc_lit", new_pc, 32'hBFC00380);
        cycle();
        #1;
        chk("exc_after_flush", flush, 1'b0);
        cycle();

        // eret with the fetch still busy for three drain cycles
        exc_valid = 1; exc_is_eret = 1; cp0_epc = 32'h80001234; if_busy = 1;
        cycle();
        exc_valid = 0; exc_is_eret = 0;
        #1;
        chk("eret_newpc_lit", new_pc, 32'h80001234);
        cycle();
        repeat (2) begin
            #1;
            chk("drain_stall_lit", stall, 7'b0000011);
            chk("drain_discard_lit", if_discard, 1'b1);
            cycle();
        end
        if_busy = 0;
        cycle();
        #1;
        chk("drain_exit_discard", if_discard, 1'b0);
        cycle();

        // reset asserted between edges while draining
        exc_valid = 1; if_busy = 1;
        cycle();
        exc_valid = 0;
        cycle();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_new_pc_zero", new_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1; if_busy = 0;
        cycle();
        #1;
        chk("rst_no_replay", flush, 1'b0);
        cycle();

        // narrow counter saturates
        stallreq_id = 1;
        repeat (20) cycle();
        chk("cnt4_saturated", stall_cnt4, 4'd15);
        stallreq_id = 0;
        cycle();

        // randomized traffic
        repeat (400) begin
            stallreq_if   = ($urandom_range(3) == 0);
            stallreq_id   = ($urandom_range(3) == 0);
            stallreq_ex   = ($urandom_range(3) == 0);
            stallreq_mem1 = ($urandom_range(3) == 0);
            stallreq_mem2 = ($urandom_range(5) == 0);
            exc_valid     = ($urandom_range(9) == 0);
            exc_is_eret   = $urandom_range(1);
            if_busy       = ($urandom_range(2) != 0);
            cp0_epc       = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline control unit for the 7-slot pipeline: pc, if, id, ex, mem1, mem2, wb.
- Produces the per-stage stall vector and the flush/redirect pulse consumed by every inter-stage pipeline register.
- Each register receives a 2-bit boundary bus {src_stalled, dst_stalled}:
  - 10 → insert bubble
  - 11 → hold
  - 0x → advance
- Sequences exception/eret redirects, including draining an in-flight instruction fetch, and keeps a stall-cycle performance counter.

Parameters:
- ADDR_W, 32, PC/address width.
- EXC_VEC, 32'hBFC00380, general exception entry address.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock.
- resetn  input  1  reset. Asynchronous, active-low.
- stallreq_if  input  1  if stage needs to hold (icache miss).
- stallreq_id  input  1  id stage load-use hazard.
- stallreq_ex  input  1  ex stage multi-cycle mul/div busy.
- stallreq_mem1  input  1  dcache miss.
- stallreq_mem2  input  1  uncached store buffer full.
- if_busy  input  1  ifetch bus transaction outstanding.
- exc_valid  input  1  exception committed at mem2.
- exc_is_eret  input  1  qualifies exc_valid as eret.
- cp0_epc  input  ADDR_W  EPC value for eret.
- stall  output  7  bit k = slot k stalled (0=pc … 6=wb).
- stall_pcif, stall_ifid, stall_idex, stall_expt1_mempt1, stall_mem1mem2, stall_mem2wb  output  2 each  boundary buses {stall[k], stall[k+1]}.
- flush  output  1  clears all pipeline registers.
- new_pc  output  ADDR_W  redirect target.
- new_pc_valid  output  1  pc must load new_pc.
- if_discard  output  1  drop the returning fetch data.
- stall_cnt  output  CNT_W  cycles with any stall bit set.

Behaviour:
- Reset (async, resetn=0):
  - state=RUN; all outputs 0, including new_pc and stall_cnt.
  - Outputs are zeroed immediately, not at the next edge.
- Stall vector, RUN state (combinational):
  - A request from slot j stalls slots 0..j. So stall[k] = OR of stallreq_j for j ≥ k.
  - stall[6] is always 0.
  - Stalled slot j with slot j+1 free produces bubble code 10 on boundary j/j+1.
- FSM states: RUN, FLUSH, DRAIN.
  - RUN → FLUSH when exc_valid=1 at a clock edge.
    - Detection cycle (combinational): stall forced to 7'b0111111, so wb takes a bubble and nothing is duplicated.
    - Target registered: cp0_epc if exc_is_eret, else EXC_VEC.
    - if_busy is sampled into busy_at_flush.
  - FLUSH: exactly one cycle.
    - flush=1, new_pc_valid=1, new_pc=target, stall=0.
    - Next state is DRAIN if busy_at_flush or if_busy, else RUN.
  - DRAIN:
    - stall=7'b0000011, if_discard=1, flush=0, new_pc_valid=0.
    - Stays until if_busy=0 at an edge, then → RUN.
    - if_discard is deasserted the cycle after if_busy falls.
  - In FLUSH and DRAIN, all stallreq_* and exc_valid inputs are ignored; the pipeline is empty by construction.
- new_pc holds its last target value until the next redirect.
- stall_cnt:
  - Increments on each edge where stall≠0, in any state.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Simultaneous events:
  - exc_valid together with any stallreq: the exception wins.
  - stallreq_* are don't-care in the detection cycle.
- Reset mid-DRAIN: returns to RUN; no redirect is replayed.

Decomposition:
- Shared defines header (existing `stall_module_bus` style), adding:
  - slot indices (SLOT_PC … SLOT_WB);
  - boundary codes (BND_ADV=2'b00/2'b01, BND_BUBBLE=2'b10, BND_HOLD=2'b11);
  - FSM state encodings;
  - EXC_VEC default.
- One natural sub-module: sat_counter (parameter CNT_W, inputs inc and resetn, saturating output).
- Stall-vector OR-chain and FSM stay in pipe_stall_ctrl.

Test Plan:
- stallreq_ex=1 in RUN → stall=7'b0001111, stall_expt1_mempt1=2'b10, stall_idex=2'b11. Release → stall=0 the same cycle.
- stallreq_if=1 and stallreq_mem2=1 together → stall=7'b0111111, stall_mem2wb=2'b10; stall_cnt +1 per cycle.
- exc_valid=1, exc_is_eret=0, if_busy=0:
  - detection cycle stall=7'b0111111;
  - next cycle flush=1, new_pc_valid=1, new_pc=0xBFC00380;
  - following cycle RUN with flush=0.
- eret with cp0_epc=0x80001234, if_busy=1 for 3 cycles after FLUSH:
  - FLUSH cycle new_pc=0x80001234;
  - then 3 cycles of stall=7'b0000011, if_discard=1;
  - then RUN with if_discard=0.
- resetn driven low mid-DRAIN between clock edges → all outputs 0 before the next edge; after release, state is RUN and no flush pulse occurs.
- CNT_W=4, stallreq_id held for 20 cycles → stall_cnt reaches 15 and stays 15.
